operand_collector_array: RTL

- Downstream consumer of the per-bank request FIFO stage. It receives register-file bank read data tagged with the 4-bit ocid that the request FIFO issued.
- It assembles Src1/Src2 operands into per-instruction collector slots.
- It dispatches complete operand sets to the execution stage with a valid/ready handshake.
- It reports free collector slots back to the register allocation unit (RAU).

---
 rtl/operand_collector_array_pkg.sv | 48 ++++
 rtl/operand_collector_array_if.sv | 37 +++
 rtl/operand_collector_array_slot.sv | 141 ++++++++++++++
 rtl/operand_collector_array.sv | 129 ++++++++++++
 4 files changed

// File: rtl/operand_collector_array_pkg.sv
// Shared types and constants for the operand collector array.
package oc_pkg;

  localparam int unsigned NUM_OC      = 8;
  localparam int unsigned NUM_BANK    = 4;
  localparam int unsigned DATA_W      = 256;
  localparam int unsigned TAG_W       = 8;
  localparam int unsigned SLOT_W      = 3;
  localparam int unsigned OCID_W      = 4;
  localparam int unsigned SRC_SEL_BIT = 3;
  localparam int unsigned SLOT_LSB    = 0;

  typedef enum logic [1:0] {
    ST_FREE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_READY   = 2'd2
  } slot_state_e;

  // Allocation payload latched into a slot.
  typedef struct packed {
    logic             need1;
    logic             need2;
    logic [TAG_W-1:0] tag;
  } alloc_req_t;

  // Result of a round-robin search.
  typedef struct packed {
    logic              vld;
    logic [SLOT_W-1:0] idx;
  } rr_pick_t;

  // First requester at or after ptr, wrapping modulo NUM_OC.
  function automatic rr_pick_t rr_pick(input logic [NUM_OC-1:0] req,
                                       input logic [SLOT_W-1:0] ptr);
    rr_pick_t          res;
    logic [SLOT_W-1:0] idx;
    res = '0;
    for (int unsigned k = 0; k < NUM_OC; k++) begin
      idx = SLOT_W'((32'(ptr) + k) % NUM_OC);
      if (!res.vld && req[idx]) begin
        res.vld = 1'b1;
        res.idx = idx;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/operand_collector_array_if.sv
// Allocation, bank read-return and dispatch bus of the operand collector array.
interface operand_collector_array_if;
  import oc_pkg::*;

  logic                         alloc_valid;
  logic [SLOT_W-1:0]            alloc_ocid;
  logic                         alloc_src1_need;
  logic                         alloc_src2_need;
  logic [TAG_W-1:0]             alloc_tag;
  logic                         alloc_err;
  logic [NUM_BANK-1:0]          rd_valid_b;
  logic [OCID_W*NUM_BANK-1:0]   rd_ocid_b;
  logic [DATA_W*NUM_BANK-1:0]   rd_data_b;
  logic                         rd_err;
  logic [NUM_OC-1:0]            oc_free;
  logic                         disp_valid;
  logic                         disp_ready;
  logic [SLOT_W-1:0]            disp_ocid;
  logic [TAG_W-1:0]             disp_tag;
  logic [DATA_W-1:0]            disp_src1;
  logic [DATA_W-1:0]            disp_src2;

  modport master (
    output alloc_valid, alloc_ocid, alloc_src1_need, alloc_src2_need, alloc_tag,
    output rd_valid_b, rd_ocid_b, rd_data_b, disp_ready,
    input  alloc_err, rd_err, oc_free,
    input  disp_valid, disp_ocid, disp_tag, disp_src1, disp_src2
  );

  modport slave (
    input  alloc_valid, alloc_ocid, alloc_src1_need, alloc_src2_need, alloc_tag,
    input  rd_valid_b, rd_ocid_b, rd_data_b, disp_ready,
    output alloc_err, rd_err, oc_free,
    output disp_valid, disp_ocid, disp_tag, disp_src1, disp_src2
  );

endinterface

// File: rtl/operand_collector_array_slot.sv
// One collector slot: state, need/have flags, tag and operand registers,
// with lowest-bank-wins capture of bank read returns.
// OC_BYPASS_EN exposes same-cycle completion and forwarded operands.
module oc_slot
  import oc_pkg::*;
#(
  parameter int unsigned SLOT_IDX = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_alloc,
  input  alloc_req_t                 i_alloc_req,
  input  logic [NUM_BANK-1:0]        i_rd_valid,
  input  logic [OCID_W*NUM_BANK-1:0] i_rd_ocid,
  input  logic [DATA_W*NUM_BANK-1:0] i_rd_data,
  input  logic                       i_disp_fire,
  output slot_state_e                o_state,
  output logic                       o_free,
  output logic [TAG_W-1:0]           o_tag,
  output logic [DATA_W-1:0]          o_src1,
  output logic [DATA_W-1:0]          o_src2,
`ifdef OC_BYPASS_EN
  output logic                       o_byp_c,
  output logic [DATA_W-1:0]          o_fwd1_c,
  output logic [DATA_W-1:0]          o_fwd2_c,
`endif
  output logic                       o_rd_err_c
);

  slot_state_e       r_state;
  slot_state_e       w_state_n;
  logic              r_free;
  logic              r_need1, r_need2, r_have1, r_have2;
  logic [TAG_W-1:0]  r_tag;
  logic [DATA_W-1:0] r_src1, r_src2;
  logic              w_take1, w_take2, w_err, w_done;
  logic [DATA_W-1:0] w_cap1, w_cap2;

  // Bank return capture: first (lowest) bank per source wins, all others flag an error.
  always_comb begin
    logic [OCID_W-1:0] v_ocid;
    v_ocid  = '0;
    w_take1 = 1'b0;
    w_take2 = 1'b0;
    w_cap1  = r_src1;
    w_cap2  = r_src2;
    w_err   = 1'b0;
    for (int b = 0; b < int'(NUM_BANK); b++) begin
      v_ocid = i_rd_ocid[b*OCID_W +: OCID_W];
      if (i_rd_valid[b] && (v_ocid[SLOT_LSB +: SLOT_W] == SLOT_W'(SLOT_IDX))) begin
        if (!v_ocid[SRC_SEL_BIT]) begin
          if ((r_state == ST_COLLECT) && r_need1 && !r_have1 && !w_take1) begin
            w_take1 = 1'b1;
            w_cap1  = i_rd_data[b*DATA_W +: DATA_W];
          end else begin
            w_err = 1'b1;
          end
        end else begin
          if ((r_state == ST_COLLECT) && r_need2 && !r_have2 && !w_take2) begin
            w_take2 = 1'b1;
            w_cap2  = i_rd_data[b*DATA_W +: DATA_W];
          end else begin
            w_err = 1'b1;
          end
        end
      end
    end
    w_done = (r_have1 | w_take1 | ~r_need1) & (r_have2 | w_take2 | ~r_need2);
  end

  // Slot state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_FREE;
      r_free  <= 1'b1;
    end else begin
      r_state <= w_state_n;
      r_free  <= (w_state_n == ST_FREE);
    end
  end

  // Next-state: a COLLECT slot completing while being dispatched (bypass) frees directly.
  always_comb begin
    w_state_n = r_state;
    case (r_state)
      ST_FREE: begin
        if (i_alloc) begin
          w_state_n = (i_alloc_req.need1 | i_alloc_req.need2) ? ST_COLLECT : ST_READY;
        end
      end
      ST_COLLECT: begin
        if (w_done) begin
          w_state_n = i_disp_fire ? ST_FREE : ST_READY;
        end
      end
      ST_READY: begin
        if (i_disp_fire) begin
          w_state_n = ST_FREE;
        end
      end
      default: w_state_n = ST_FREE;
    endcase
  end

  // Flag, tag and operand registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_need1 <= 1'b0;
      r_need2 <= 1'b0;
      r_have1 <= 1'b0;
      r_have2 <= 1'b0;
      r_tag   <= '0;
      r_src1  <= '0;
      r_src2  <= '0;
    end else if ((r_state == ST_FREE) && i_alloc) begin
      r_need1 <= i_alloc_req.need1;
      r_need2 <= i_alloc_req.need2;
      r_have1 <= 1'b0;
      r_have2 <= 1'b0;
      r_tag   <= i_alloc_req.tag;
    end else begin
      r_have1 <= r_have1 | w_take1;
      r_have2 <= r_have2 | w_take2;
      r_src1  <= w_cap1;
      r_src2  <= w_cap2;
    end
  end

  assign o_state    = r_state;
  assign o_free     = r_free;
  assign o_tag      = r_tag;
  assign o_src1     = r_src1;
  assign o_src2     = r_src2;
  assign o_rd_err_c = w_err;
`ifdef OC_BYPASS_EN
  assign o_byp_c  = (r_state == ST_COLLECT) & (w_take1 | w_take2) & w_done;
  assign o_fwd1_c = w_cap1;
  assign o_fwd2_c = w_cap2;
`endif

endmodule

// File: rtl/operand_collector_array.sv
// Operand collector array: slot allocation decode, round-robin dispatch
// arbiter with stall hold, and registered alloc/read-return error pulses.
// Optional macro OC_BYPASS_EN: 0-cycle arrival-to-dispatch with forwarded data.
module operand_collector_array
  import oc_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  operand_collector_array_if.slave  bus
);

  alloc_req_t        w_alloc_req;
  slot_state_e       w_state [NUM_OC];
  logic [TAG_W-1:0]  w_tag   [NUM_OC];
  logic [DATA_W-1:0] w_src1  [NUM_OC];
  logic [DATA_W-1:0] w_src2  [NUM_OC];
  logic [NUM_OC-1:0] w_free, w_ready, w_err_vec;
`ifdef OC_BYPASS_EN
  logic [DATA_W-1:0] w_fwd1  [NUM_OC];
  logic [DATA_W-1:0] w_fwd2  [NUM_OC];
  logic [NUM_OC-1:0] w_byp;
  logic              w_sel_byp;
  rr_pick_t          w_pick_byp;
`endif
  rr_pick_t          w_pick_rdy;
  logic              w_valid, w_fire;
  logic [SLOT_W-1:0] w_sel;
  logic [SLOT_W-1:0] r_ptr, r_lock_id;
  logic              r_lock, r_alloc_err, r_rd_err;

  assign w_alloc_req = '{need1: bus.alloc_src1_need,
                         need2: bus.alloc_src2_need,
                         tag:   bus.alloc_tag};

  for (genvar g = 0; g < int'(NUM_OC); g++) begin : g_slot
    oc_slot #(.SLOT_IDX(g)) u_slot (
      .clk         (clk),
      .rst         (rst),
      .i_alloc     (bus.alloc_valid && (bus.alloc_ocid == SLOT_W'(g))),
      .i_alloc_req (w_alloc_req),
      .i_rd_valid  (bus.rd_valid_b),
      .i_rd_ocid   (bus.rd_ocid_b),
      .i_rd_data   (bus.rd_data_b),
      .i_disp_fire (w_fire && (w_sel == SLOT_W'(g))),
      .o_state     (w_state[g]),
      .o_free      (w_free[g]),
      .o_tag       (w_tag[g]),
      .o_src1      (w_src1[g]),
      .o_src2      (w_src2[g]),
`ifdef OC_BYPASS_EN
      .o_byp_c     (w_byp[g]),
      .o_fwd1_c    (w_fwd1[g]),
      .o_fwd2_c    (w_fwd2[g]),
`endif
      .o_rd_err_c  (w_err_vec[g])
    );
    assign w_ready[g] = (w_state[g] == ST_READY);
  end

  // Dispatch selection: held slot while stalled, else registered READY, else bypass.
  always_comb begin
    w_pick_rdy = rr_pick(w_ready, r_ptr);
    w_valid    = 1'b0;
    w_sel      = '0;
`ifdef OC_BYPASS_EN
    w_pick_byp = rr_pick(w_byp, r_ptr);
    w_sel_byp  = 1'b0;
`endif
    if (r_lock) begin
      w_valid = w_ready[r_lock_id];
      w_sel   = r_lock_id;
    end else if (w_pick_rdy.vld) begin
      w_valid = 1'b1;
      w_sel   = w_pick_rdy.idx;
`ifdef OC_BYPASS_EN
    end else if (w_pick_byp.vld) begin
      w_valid   = 1'b1;
      w_sel     = w_pick_byp.idx;
      w_sel_byp = 1'b1;
`endif
    end
  end

  assign w_fire = w_valid & bus.disp_ready;

  // Dispatch payload, zero when nothing is presented.
  always_comb begin
    bus.disp_valid = w_valid;
    bus.disp_ocid  = '0;
    bus.disp_tag   = '0;
    bus.disp_src1  = '0;
    bus.disp_src2  = '0;
    if (w_valid) begin
      bus.disp_ocid = w_sel;
      bus.disp_tag  = w_tag[w_sel];
`ifdef OC_BYPASS_EN
      bus.disp_src1 = w_sel_byp ? w_fwd1[w_sel] : w_src1[w_sel];
      bus.disp_src2 = w_sel_byp ? w_fwd2[w_sel] : w_src2[w_sel];
`else
      bus.disp_src1 = w_src1[w_sel];
      bus.disp_src2 = w_src2[w_sel];
`endif
    end
  end

  // Arbiter pointer, stall hold and error pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr       <= '0;
      r_lock      <= 1'b0;
      r_lock_id   <= '0;
      r_alloc_err <= 1'b0;
      r_rd_err    <= 1'b0;
    end else begin
      r_lock      <= w_valid & ~bus.disp_ready;
      r_lock_id   <= w_sel;
      r_alloc_err <= bus.alloc_valid & ~w_free[bus.alloc_ocid];
      r_rd_err    <= |w_err_vec;
      if (w_fire) begin
        r_ptr <= SLOT_W'((32'(w_sel) + 32'd1) % NUM_OC);
      end
    end
  end

  assign bus.alloc_err = r_alloc_err;
  assign bus.rd_err    = r_rd_err;
  assign bus.oc_free   = w_free;

endmodule
